// File: rtl/prio_encoder_rr_pkg.sv
// Shared types and helpers for the registered priority encoder.
package prio_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Combinational descending scan from 'start', wrapping N-1 after 0; first set bit wins.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         hit
);

    always_comb begin
        int unsigned start_u;
        int unsigned k;
        logic [W-1:0] pos;
        start_u = 32'(start);
        k       = 0;
        pos     = '0;
        idx     = '0;
        hit     = |req;
        // Walk from the farthest scan position back to 'start' so the nearest hit overwrites last.
        for (int unsigned j = 0; j < N; j++) begin
            k   = N - 1 - j;
            pos = W'((start_u >= k) ? (start_u - k) : (start_u + N - k));
            if (req[pos]) begin
                idx = pos;
            end
        end
        onehot = hit ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready output.
// Define PRIO_ENC_RR_EN for round-robin selection; default is fixed highest-index-first.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    state_t       state_q;
    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [N-1:0] onehot_q;

    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         pick_hit;
    logic         load;

    assign load = en && pick_hit && ((state_q == IDLE) || out_ready);

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Granted line drops to lowest priority on the next scan.
    assign ptr_d = (pick_idx == '0) ? W'(N - 1) : (pick_idx - W'(1));
    assign start = ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(N - 1);
        end else if (load) begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = W'(N - 1);
`endif

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req    (req),
        .start  (start),
        .idx    (pick_idx),
        .onehot (pick_onehot),
        .hit    (pick_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && pick_hit) begin
                        idx_q    <= pick_idx;
                        onehot_q <= pick_onehot;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (en && pick_hit) begin
                            idx_q    <= pick_idx;
                            onehot_q <= pick_onehot;
                            valid_q  <= 1'b1;
                        end else begin
                            // Index keeps its last value; only valid and one-hot clear.
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed self-checking bench for prio_encoder_rr (N=8 and N=5 instances).
module tb_prio_encoder_rr;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;

    logic       en5;
    logic [4:0] req5;
    logic       ready5;
    logic       valid5;
    logic [2:0] idx5;
    logic [4:0] onehot5;

    int errors = 0;
    int checks = 0;

    prio_encoder_rr #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    prio_encoder_rr #(.N(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en5),
        .req        (req5),
        .out_ready  (ready5),
        .out_valid  (valid5),
        .out_idx    (idx5),
        .out_onehot (onehot5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 8'h00; out_ready = 1'b0;
        en5 = 1'b0; req5 = '0; ready5 = 1'b0;
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: valid=%b idx=%0d onehot=%h, want 0/0/00",
                         i, out_valid, out_idx, out_onehot);
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 8'hFF; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_low_noload: valid=%b want 0", out_valid);
        end
        req = 8'h00; en = 1'b1; out_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'b0010_1100; en = 1'b1; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_onehot !== 8'h20) begin
            errors++;
            $display("FAIL hold_load: valid=%b idx=%0d onehot=%h, want 1/5/20",
                     out_valid, out_idx, out_onehot);
        end
        req = 8'h01;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_onehot !== 8'h20) begin
                errors++;
                $display("FAIL hold_frozen cyc%0d: valid=%b idx=%0d onehot=%h, want 1/5/20",
                         i, out_valid, out_idx, out_onehot);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_onehot !== 8'h01) begin
            errors++;
            $display("FAIL hold_handshake: valid=%b idx=%0d onehot=%h, want 1/0/01",
                     out_valid, out_idx, out_onehot);
        end
        req = 8'h00;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00) begin
            errors++;
            $display("FAIL hold_drain: valid=%b idx=%0d onehot=%h, want 0/0/00",
                     out_valid, out_idx, out_onehot);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_idx;
        do_reset();
        req = 8'hFF; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef PRIO_ENC_RR_EN
            exp_idx = 3'(7 - i);
`else
            exp_idx = 3'd7;
`endif
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx) begin
                errors++;
                $display("FAIL b2b cyc%0d: valid=%b idx=%0d, want 1/%0d",
                         i, out_valid, out_idx, exp_idx);
            end
        end
        req = 8'h00;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rr_sequence();
        logic [2:0] exp_seq [6];
`ifdef PRIO_ENC_RR_EN
        exp_seq = '{3'd7, 3'd1, 3'd0, 3'd7, 3'd1, 3'd0};
`else
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        do_reset();
        req = 8'b1000_0011; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin
                errors++;
                $display("FAIL rr_seq grant%0d: valid=%b idx=%0d, want 1/%0d",
                         i, out_valid, out_idx, exp_seq[i]);
            end
        end
        req = 8'h00;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h08; en = 1'b1; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre: valid=%b idx=%0d, want 1/3", out_valid, out_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || out_idx !== 3'd0) begin
            errors++;
            $display("FAIL areset_immediate: valid=%b idx=%0d onehot=%h, want 0/0/00",
                     out_valid, out_idx, out_onehot);
        end
        req = 8'h10;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_onehot !== 8'h10) begin
            errors++;
            $display("FAIL areset_first_grant: valid=%b idx=%0d onehot=%h, want 1/4/10",
                     out_valid, out_idx, out_onehot);
        end
        req = 8'h00;
    endtask

    task automatic test_n5();
        do_reset();
        req5 = 5'b10000; en5 = 1'b1; ready5 = 1'b0;
        tick();
        checks++;
        if (valid5 !== 1'b1 || idx5 !== 3'd4 || onehot5 !== 5'b10000) begin
            errors++;
            $display("FAIL n5_load: valid=%b idx=%0d onehot=%b, want 1/4/10000",
                     valid5, idx5, onehot5);
        end
        en5 = 1'b0; ready5 = 1'b1;
        tick();
        checks++;
        if (valid5 !== 1'b0 || idx5 !== 3'd4 || onehot5 !== 5'b00000) begin
            errors++;
            $display("FAIL n5_drain: valid=%b idx=%0d onehot=%b, want 0/4/00000",
                     valid5, idx5, onehot5);
        end
        tick();
        checks++;
        if (valid5 !== 1'b0 || idx5 !== 3'd4) begin
            errors++;
            $display("FAIL n5_idle_ready: valid=%b idx=%0d, want 0/4", valid5, idx5);
        end
        ready5 = 1'b0; req5 = '0;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_hold();
        test_back_to_back();
        test_rr_sequence();
        test_async_reset();
        test_n5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready output handshake. It is the sequential successor of the lab 8-to-3 encoder. Each cycle it selects one asserted request line and holds the encoded index stable until a consumer accepts it. Selection is fixed highest-index-first by default; an optional round-robin mode gives each line a fair share.

## Interface
Parameters:
- N, 8, number of request lines; legal range 2..256.
- W, $clog2(N), index width; derived localparam, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  encoder enable; when low, no new index is loaded.
- req  in  N  request lines; bit i set means line i is requesting.
- out_ready  in  1  consumer accepts the current index.
- out_valid  out  1  out_idx/out_onehot hold a valid selection.
- out_idx  out  W  binary index of the selected line.
- out_onehot  out  N  one-hot form of out_idx; all zero when out_valid=0.

## Operation
- Two states, IDLE and HOLD; reset state is IDLE.
- Reset values: out_valid=0, out_idx=0, out_onehot=0; round-robin pointer ptr=N-1.
- Pick function, combinational on req:
  - Fixed mode: highest set bit wins.
  - RR mode: scan descending from ptr, wrapping N-1 after 0; first set bit wins.
  - hit = |req.
- IDLE: if en && hit, register the pick into out_idx/out_onehot, set out_valid=1, go to HOLD. Otherwise stay; outputs unchanged.
- HOLD: outputs frozen regardless of req/en changes while out_ready=0.
- HOLD with out_ready=1 (handshake):
  - If en && hit: load the new pick the same edge and stay in HOLD (back-to-back, no bubble).
  - Else: out_valid=0, out_onehot=0, out_idx keeps its last value, go to IDLE.
- RR pointer: on every load of winner g, ptr <= (g==0) ? N-1 : g-1. The granted line therefore drops to lowest priority. Unchanged otherwise.
- req is sampled only at load edges. A request that deasserts before a load is simply missed; no capture or queueing.
- en low during HOLD does not cancel the pending output. It only blocks the reload after handshake.

## Timing
- Latency: req/en at edge k produces out_valid/out_idx after edge k, visible in cycle k+1.
- Throughput: one index per cycle with out_ready tied high and requests continuously present.
- out_ready is ignored while out_valid=0; out_ready=1 in IDLE has no effect.
- rst_n assertion mid-HOLD clears outputs and ptr immediately, without waiting for clk. Deassertion is synchronised externally; the first load is allowed at the first edge after release.
- All outputs are registered; no combinational path from req or out_ready to any output.

## Configuration
- PRIO_ENC_RR_EN defined: round-robin pick and ptr register are compiled in.
- PRIO_ENC_RR_EN undefined: fixed highest-index priority, identical to a stateless priority encode; ptr is not instantiated.
- The ports are identical in both builds.

## Structure
- Package prio_enc_pkg holds:
  - state typedef (IDLE, HOLD).
  - function idx_w(N) returning max(1, $clog2(N)).
- Sub-module prio_pick (combinational): inputs req, start; outputs idx, onehot, hit. Descending scan with wrap.
  - Fixed build ties start to N-1.
  - RR build drives start from ptr.

## Test plan
- Reset, N=8, req=8'h00, en=1 for 5 cycles -> out_valid stays 0, out_idx=0, out_onehot=0.
- Fixed mode, req=8'b0010_1100, en=1, out_ready=0 -> next cycle out_valid=1, out_idx=5, out_onehot=8'h20. Change req to 8'h01 -> out_idx stays 5 until out_ready=1; following cycle out_idx=0.
- Fixed mode, req=8'hFF, out_ready=1 constantly -> out_idx=7 every cycle, out_valid never drops.
- RR build, req=8'b1000_0011, out_ready=1 -> grant sequence 7,1,0,7,1,0.
- HOLD with out_idx=3: pulse rst_n low between clock edges -> out_valid=0 and out_onehot=0 immediately. After release with req=8'h10, first grant is 4.
- N=5 build, req=5'b10000, then handshake with en=0 -> out_idx=4 (W=3), then out_valid=0 and state returns to IDLE.
